bin2bcd_seq: RTL

//   Sequential binary-to-packed-BCD converter (shift-and-add-3, one bit per clock).

---
 rtl/bcd_pkg.sv | 21 ++
 rtl/bcd_digit_adj.sv | 12 +
 rtl/bin2bcd_seq.sv | 113 +++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD constants and converter state encoding, common to the binary-to-BCD
// converter and the downstream 2-digit BCD adder.
package bcd_pkg;

  localparam int BCD_DIGIT_W = 4;

  // Shift-and-add-3 digit adjust
  localparam logic [BCD_DIGIT_W-1:0] ADJ_THRESH = 4'd5;
  localparam logic [BCD_DIGIT_W-1:0] ADJ_ADD    = 4'd3;

  // Adder decimal-correction constants
  localparam logic [BCD_DIGIT_W-1:0] ADD_CORR_THRESH = 4'd10;
  localparam logic [BCD_DIGIT_W-1:0] ADD_CORR        = 4'd6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_digit_adj.sv
// One BCD digit of the shift-and-add-3 step: digits of 5 or more get +3 so the
// following left shift carries correctly into the next decimal digit.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] i_din,
  output logic [BCD_DIGIT_W-1:0] o_dout
);

  assign o_dout = (i_din >= ADJ_THRESH) ? (i_din + ADJ_ADD) : i_din;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-packed-BCD converter, one bit per clock, valid/ready on both
// sides. Overflow flags operands above 10^DIGITS-1; bcd then holds bin mod 10^DIGITS.
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int IN_W   = 7,
  parameter int DIGITS = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [IN_W-1:0]               bin,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
  output logic                          ovf
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(IN_W + 1);

  state_t             r_state, w_state_next;
  logic [IN_W-1:0]    r_bin, w_bin_next;
  logic [BCD_W-1:0]   r_work, w_work_next;
  logic               r_ovf_work, w_ovf_work_next;
  logic [CNT_W-1:0]   r_cnt, w_cnt_next;
  logic [BCD_W-1:0]   r_bcd, w_bcd_next;
  logic               r_ovf, w_ovf_next;

  logic [BCD_W-1:0]   w_adj;
  logic               w_carry;
  logic [BCD_W-1:0]   w_work_sh;
  logic [IN_W-1:0]    w_bin_sh;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
    bcd_digit_adj u_adj (
      .i_din  (r_work[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .o_dout (w_adj[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // The bit leaving the top digit is the hundreds (overflow) carry
  assign {w_carry, w_work_sh, w_bin_sh} = {w_adj, r_bin, 1'b0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_bin      <= '0;
      r_work     <= '0;
      r_ovf_work <= 1'b0;
      r_cnt      <= '0;
      r_bcd      <= '0;
      r_ovf      <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_bin      <= w_bin_next;
      r_work     <= w_work_next;
      r_ovf_work <= w_ovf_work_next;
      r_cnt      <= w_cnt_next;
      r_bcd      <= w_bcd_next;
      r_ovf      <= w_ovf_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_bin_next      = r_bin;
    w_work_next     = r_work;
    w_ovf_work_next = r_ovf_work;
    w_cnt_next      = r_cnt;
    w_bcd_next      = r_bcd;
    w_ovf_next      = r_ovf;
    in_ready        = 1'b0;
    out_valid       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_bin_next      = bin;
          w_work_next     = '0;
          w_ovf_work_next = 1'b0;
          w_cnt_next      = CNT_W'(IN_W);
          w_state_next    = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        w_bin_next      = w_bin_sh;
        w_work_next     = w_work_sh;
        w_ovf_work_next = r_ovf_work | w_carry;
        w_cnt_next      = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          w_bcd_next   = w_work_sh;
          w_ovf_next   = r_ovf_work | w_carry;
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign bcd = r_bcd;
  assign ovf = r_ovf;

endmodule
